int_ctrl_nested: RTL and testbench
==================================

Name: int_ctrl_nested

Overview:
- Three-level nested priority interrupt controller.
- Receives the external request lines inter1..inter3 and drives the inter_running1..3 status outputs.
- Sits between the board/bench request pins and the MIPS CPU core. Presents one request plus a handler vector to the CPU, and tracks nesting through CPU accept (int_ack) and return (eret) strobes.
- Priority order: inter3 > inter2 > inter1. A higher level preempts a running lower level.

Parameters:
- VEC_BASE, 32'h0000_0100, handler address for level 1.
- VEC_STRIDE, 32'h0000_0020, address step between consecutive levels.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; one clock; reset is synchronous and active-high.
- inter1  in  1  level-1 request (lowest priority).
- inter2  in  1  level-2 request.
- inter3  in  1  level-3 request (highest priority).
- ie  in  1  global interrupt enable from CPU status.
- int_ack  in  1  CPU accepts the presented request this cycle.
- eret  in  1  CPU returns from the current handler this cycle.
- int_req  out  1  request to CPU.
- int_vec  out  32  handler address for the presented level.
- int_level  out  2  presented level, 1..3; 0 when int_req is low.
- inter_running1  out  1  level 1 is in service (possibly preempted).
- inter_running2  out  1  level 2 is in service.
- inter_running3  out  1  level 3 is in service.

Behaviour:
- Reset (clr=1 at an edge): all pending bits, running bits and edge-history registers are cleared, and the FSM returns to IDLE. Outputs after reset: int_req=0, int_vec=0, int_level=0, inter_running1..3=0. Reset mid-request or mid-handler discards all state.
- Capture:
  - Each input is sampled every clk.
  - Pending bit k is set on a sampled 0->1 transition of interk. The bit is sticky until accepted.
  - A held-high input sets pending only once.
  - An edge in the same cycle as the ack of the same level leaves pending set, i.e. re-pends.
- Current level: cur = index of the highest set running bit, or 0 if none.
- Candidate: cand = index of the highest set pending bit with cand > cur. No candidate if none qualifies.
- FSM states:
  - IDLE: int_req=0. Go to REQ when ie=1 and a candidate exists. The decision is registered, so int_req rises 1 cycle after the pending bit is set.
  - REQ: int_req=1, int_level=cand, int_vec = VEC_BASE + (cand-1)*VEC_STRIDE.
    - cand is re-evaluated every cycle. A higher pending level arriving before ack updates int_level/int_vec, and int_req stays high.
    - If ie drops, or the candidate disappears (for example, eret is not involved but running changes), return to IDLE with int_req=0.
    - On int_ack: set running[cand], clear pending[cand], go to IDLE. int_req deasserts in the next cycle.
- int_ack while int_req=0 is ignored.
- eret clears the highest running bit set at the start of the cycle. eret with nothing running is ignored.
- Simultaneous int_ack and eret: eret clears the pre-existing highest running bit, and ack sets running[cand]; both are applied.
- A lower-level request arriving while a higher level runs stays pending. It is presented only after the higher level's eret.
- inter_runningk = running[k] (registered, no combinational path from inputs).
- All arithmetic is 32-bit unsigned. The vector offset never exceeds 2*VEC_STRIDE.

Optional Feature:
- Macro INT_CTRL_STAT_EN.
- When defined:
  - Adds output int_count (32 bits): number of accepted interrupts. It increments on each int_ack while int_req=1, resets to 0 on clr, and wraps 0xFFFF_FFFF->0.
  - Adds output int_max_depth (2 bits): peak number of running bits set simultaneously since reset.
- When undefined: neither port nor any counter logic exists. Core behaviour is identical.

Decomposition:
- Shared package int_pkg holds:
  - level encodings LVL_NONE=2'd0, LVL_1..LVL_3;
  - the FSM state typedef (IDLE, REQ);
  - NUM_LEVELS=3.
- One sub-module, int_edge_latch: one instance per source, holding the input history register and the sticky pending bit with set/clear ports.
- Priority/vector logic stays in int_ctrl_nested.

Test Plan:
- Reset then idle: clr=1 for 2 cycles, inputs low -> int_req=0, int_vec=0, inter_running1..3=0 for 10 cycles.
- Single level-1 pulse with ie=1:
  - int_req rises and int_vec=0x100, int_level=1.
  - ack -> inter_running1=1, int_req=0.
  - eret -> inter_running1=0.
- Preemption 3 over 1: level 1 is running, then an inter3 pulse -> int_req with int_vec=0x140. Ack -> inter_running1=1 and inter_running3=1. First eret clears only running3; second eret clears running1.
- Low during high: level 3 is running, then an inter1 pulse -> int_req stays 0 until eret of level 3. Then int_req=1 with int_vec=0x100.
- Upgrade before ack: inter2 pending with int_req=1 and vec 0x120, then an inter3 pulse before ack -> vec changes to 0x140 and int_req stays 1. Ack services level 3; level 2 is re-presented next.
- Gating and re-pend: with ie=0, pulse inter2 -> no int_req. Raising ie -> int_req within 2 cycles. An inter2 edge coincident with its ack -> pending remains set, and int_req reasserts after the level-2 eret.

Source files
------------

// File: rtl/int_pkg.sv
// Shared definitions for the nested interrupt controller.
//   NUM_LEVELS      : number of request levels (1..3, level 3 highest)
//   LVL_*           : 2-bit level encodings, LVL_NONE means "no level"
//   int_state_e     : request FSM states
//   highest_lvl()   : index of the highest set bit of a level vector
//   lvl_onehot()    : level index to one-hot level vector
package int_pkg;

    localparam int NUM_LEVELS = 3;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } int_state_e;

    function automatic logic [1:0] highest_lvl(input logic [NUM_LEVELS:1] v);
        logic [1:0] lvl;
        if (v[3])      lvl = LVL_3;
        else if (v[2]) lvl = LVL_2;
        else if (v[1]) lvl = LVL_1;
        else           lvl = LVL_NONE;
        return lvl;
    endfunction

    function automatic logic [NUM_LEVELS:1] lvl_onehot(input logic [1:0] lvl);
        logic [NUM_LEVELS:1] m;
        for (int k = 1; k <= NUM_LEVELS; k++) begin
            m[k] = (lvl == 2'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge capture for one interrupt source.
//   clk      : system clock
//   clr      : synchronous active-high reset
//   req_i    : raw request line, sampled every clock
//   ack_clr_i: clears the pending bit (request accepted)
//   pend_o   : sticky pending bit
// A new edge wins over a simultaneous clear so that the source re-pends.
module int_edge_latch (
    input  logic clk,
    input  logic clr,
    input  logic req_i,
    input  logic ack_clr_i,
    output logic pend_o
);

    logic hist_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = req_i & ~hist_q;

    always_comb begin
        pend_d = pend_q;
        if (rise)           pend_d = 1'b1;
        else if (ack_clr_i) pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hist_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            hist_q <= req_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/int_ctrl_nested.sv
// Three-level nested priority interrupt controller (inter3 > inter2 > inter1).
// Presents one request with its handler vector to the CPU, and tracks nesting
// through int_ack (accept) and eret (return) strobes.
//   clk, clr             : clock, synchronous active-high reset
//   inter1..inter3       : request lines, rising edge sets pending
//   ie                   : global interrupt enable
//   int_ack, eret        : CPU accept / return strobes
//   int_req, int_vec,
//   int_level            : registered request, handler address and level
//   inter_running1..3    : levels in service (possibly preempted)
// Optional build macro INT_CTRL_STAT_EN adds int_count (accepted interrupts)
// and int_max_depth (peak simultaneous running levels since reset).
//
// state | meaning
// IDLE  | no request presented; waits for ie and a qualifying candidate
// REQ   | int_req high, presenting the current candidate level
module int_ctrl_nested
    import int_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        inter1,
    input  logic        inter2,
    input  logic        inter3,
    input  logic        ie,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] int_vec,
    output logic [1:0]  int_level,
`ifdef INT_CTRL_STAT_EN
    output logic [31:0] int_count,
    output logic [1:0]  int_max_depth,
`endif
    output logic        inter_running1,
    output logic        inter_running2,
    output logic        inter_running3
);

    logic [NUM_LEVELS:1] req_v;
    logic [NUM_LEVELS:1] pend;
    logic [NUM_LEVELS:1] ack_clr;
    logic [NUM_LEVELS:1] eret_clr;
    logic [NUM_LEVELS:1] above_cur;
    logic [NUM_LEVELS:1] run_q;
    logic [NUM_LEVELS:1] run_d;
    logic [1:0]          cur;
    logic [1:0]          cand;
    logic                cand_ok;
    logic                ack_take;

    int_state_e  state_q;
    logic        int_req_q;
    logic [1:0]  int_level_q;
    logic [31:0] int_vec_q;

    assign req_v = {inter3, inter2, inter1};

    for (genvar k = 1; k <= NUM_LEVELS; k++) begin : g_src
        int_edge_latch u_latch (
            .clk      (clk),
            .clr      (clr),
            .req_i    (req_v[k]),
            .ack_clr_i(ack_clr[k]),
            .pend_o   (pend[k])
        );
    end

    function automatic logic [31:0] vec_of(input logic [1:0] lvl);
        return VEC_BASE + ({30'd0, lvl} - 32'd1) * VEC_STRIDE;
    endfunction

    // Only pending levels strictly above the level in service may be presented.
    always_comb begin
        cur = highest_lvl(run_q);
        for (int k = 1; k <= NUM_LEVELS; k++) begin
            above_cur[k] = (2'(k) > cur);
        end
        cand     = highest_lvl(pend & above_cur);
        cand_ok  = (cand != LVL_NONE);
        ack_take = (state_q == REQ) && int_ack && cand_ok;
        ack_clr  = ack_take ? lvl_onehot(cand) : '0;
        eret_clr = eret ? lvl_onehot(cur) : '0;
        // eret retires the level in service at cycle start; a same-cycle
        // accept lands on a strictly higher bit, so both apply.
        run_d    = (run_q & ~eret_clr) | ack_clr;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            int_req_q   <= 1'b0;
            int_level_q <= LVL_NONE;
            int_vec_q   <= '0;
            run_q       <= '0;
        end else begin
            run_q <= run_d;
            case (state_q)
                IDLE: begin
                    if (ie && cand_ok) begin
                        state_q     <= REQ;
                        int_req_q   <= 1'b1;
                        int_level_q <= cand;
                        int_vec_q   <= vec_of(cand);
                    end
                end
                REQ: begin
                    if (ack_take || !ie || !cand_ok) begin
                        state_q     <= IDLE;
                        int_req_q   <= 1'b0;
                        int_level_q <= LVL_NONE;
                        int_vec_q   <= '0;
                    end else begin
                        // Late higher-priority arrivals upgrade the presented level.
                        int_level_q <= cand;
                        int_vec_q   <= vec_of(cand);
                    end
                end
            endcase
        end
    end

    assign int_req        = int_req_q;
    assign int_level      = int_level_q;
    assign int_vec        = int_vec_q;
    assign inter_running1 = run_q[1];
    assign inter_running2 = run_q[2];
    assign inter_running3 = run_q[3];

`ifdef INT_CTRL_STAT_EN
    logic [31:0] count_q;
    logic [1:0]  depth_q;
    logic [1:0]  depth_d;

    assign depth_d = 2'({1'b0, run_d[1]} + {1'b0, run_d[2]} + {1'b0, run_d[3]});

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
            depth_q <= '0;
        end else begin
            if (ack_take) count_q <= count_q + 32'd1;
            if (depth_d > depth_q) depth_q <= depth_d;
        end
    end

    assign int_count     = count_q;
    assign int_max_depth = depth_q;
`endif

endmodule

// File: tb/tb_int_ctrl_nested.sv
module tb_int_ctrl_nested;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        inter1 = 1'b0, inter2 = 1'b0, inter3 = 1'b0;
    logic        ie = 1'b0, int_ack = 1'b0, eret = 1'b0;
    logic        int_req;
    logic [31:0] int_vec;
    logic [1:0]  int_level;
    logic        inter_running1, inter_running2, inter_running3;
`ifdef INT_CTRL_STAT_EN
    logic [31:0] int_count;
    logic [1:0]  int_max_depth;
`endif

    always #5 clk = ~clk;

    int_ctrl_nested dut (
        .clk           (clk),
        .clr           (clr),
        .inter1        (inter1),
        .inter2        (inter2),
        .inter3        (inter3),
        .ie            (ie),
        .int_ack       (int_ack),
        .eret          (eret),
        .int_req       (int_req),
        .int_vec       (int_vec),
        .int_level     (int_level),
`ifdef INT_CTRL_STAT_EN
        .int_count     (int_count),
        .int_max_depth (int_max_depth),
`endif
        .inter_running1(inter_running1),
        .inter_running2(inter_running2),
        .inter_running3(inter_running3)
    );

    typedef struct {
        logic        req;
        logic [1:0]  lvl;
        logic [31:0] vec;
        logic [2:0]  run;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain per-level flags.
    bit m_hist[1:3];
    bit m_pend[1:3];
    bit m_run[1:3];
    bit m_req;
    int m_lvl;

    function automatic int top_running();
        for (int k = 3; k >= 1; k--) if (m_run[k]) return k;
        return 0;
    endfunction

    function automatic int top_candidate(input int above);
        for (int k = 3; k >= 1; k--) if (m_pend[k] && k > above) return k;
        return 0;
    endfunction

    task automatic step(input bit c, input bit i1, input bit i2, input bit i3,
                        input bit en, input bit ack, input bit er);
        exp_t e;
        bit   in_v[1:3];
        int   cur, cand;
        bit   took;
        clr = c; inter1 = i1; inter2 = i2; inter3 = i3;
        ie = en; int_ack = ack; eret = er;
        in_v[1] = i1; in_v[2] = i2; in_v[3] = i3;
        if (c) begin
            for (int k = 1; k <= 3; k++) begin
                m_hist[k] = 0; m_pend[k] = 0; m_run[k] = 0;
            end
            m_req = 0; m_lvl = 0;
        end else begin
            cur  = top_running();
            cand = top_candidate(cur);
            took = m_req && ack && cand != 0;
            for (int k = 1; k <= 3; k++) begin
                if (in_v[k] && !m_hist[k]) m_pend[k] = 1;
                else if (took && k == cand) m_pend[k] = 0;
                m_hist[k] = in_v[k];
            end
            if (er && cur != 0) m_run[cur] = 0;
            if (took) m_run[cand] = 1;
            if (!m_req) begin
                m_req = en && cand != 0;
                m_lvl = cand;
            end else if (took || !en || cand == 0) begin
                m_req = 0;
            end else begin
                m_lvl = cand;
            end
            if (!m_req) m_lvl = 0;
        end
        e.req = m_req;
        e.lvl = 2'(m_lvl);
        e.vec = m_req ? 32'h100 + 32'(m_lvl - 1) * 32'h20 : 32'h0;
        e.run = {m_run[3], m_run[2], m_run[1]};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit en = 1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, en, 0, 0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!m_req && n < 8) begin
            step(0, 0, 0, 0, 1, 0, 0);
            n++;
        end
    endtask

    task automatic pulse(input int k, input bit en = 1);
        step(0, k == 1, k == 2, k == 3, en, 0, 0);
        step(0, 0, 0, 0, en, 0, 0);
    endtask

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int_req !== e.req) begin
                    errors++;
                    $display("FAIL int_req got %0b want %0b at %0t", int_req, e.req, $time);
                end
                checks++;
                if (int_level !== e.lvl) begin
                    errors++;
                    $display("FAIL int_level got %0d want %0d at %0t", int_level, e.lvl, $time);
                end
                checks++;
                if (int_vec !== e.vec) begin
                    errors++;
                    $display("FAIL int_vec got %h want %h at %0t", int_vec, e.vec, $time);
                end
                checks++;
                if ({inter_running3, inter_running2, inter_running1} !== e.run) begin
                    errors++;
                    $display("FAIL running got %b want %b at %0t",
                             {inter_running3, inter_running2, inter_running1}, e.run, $time);
                end
            end
        end
    end

    initial begin
        bit r1, r2, r3, ren, rack, rer, rclr;
        @(negedge clk);
        // Reset then idle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(10);
        // Single level-1 pulse: present, ack, return
        pulse(1);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // Preemption 3 over 1
        pulse(1);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        idle(2);
        pulse(3);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // Low during high
        pulse(3);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        pulse(1);
        idle(4);
        step(0, 0, 0, 0, 1, 0, 1);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // Upgrade before ack, then level 2 re-presented
        pulse(2);
        wait_req();
        step(0, 0, 0, 1, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 1, 0);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // Gating by ie, then edge coincident with ack re-pends
        pulse(2, 0);
        idle(4, 0);
        idle(3);
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        // Reset mid-handler
        pulse(3);
        wait_req();
        step(0, 0, 0, 0, 1, 1, 0);
        pulse(1);
        step(1, 0, 0, 0, 1, 0, 0);
        idle(4);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r1   = ($urandom_range(0, 3) == 0);
            r2   = ($urandom_range(0, 4) == 0);
            r3   = ($urandom_range(0, 6) == 0);
            ren  = ($urandom_range(0, 7) != 0);
            rack = m_req ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            rer  = ($urandom_range(0, 6) == 0);
            rclr = ($urandom_range(0, 399) == 0);
            step(rclr, r1, r2, r3, ren, rack, rer);
        end
        idle(2);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending records want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
